sample_stream_fifo: RTL and testbench

SAMPLE_STREAM_FIFO -- requirements
Module: sample_stream_fifo

---
 rtl/sample_stream_fifo.sv | 166 ++++++++++++++++
 tb/tb_sample_stream_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_stream_fifo.sv
// Wishbone-fed sample FIFO drained at a programmable rate into an FM generator.
// Bus ack 1 cycle after strobe (never stalls); o_sample 1 cycle after tick; full-FIFO pushes are dropped.
module sample_stream_fifo #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_AW      = 8,
  parameter int RATE_WIDTH   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_resetb,
  input  logic                    i_wb_cyc,
  input  logic                    i_wb_stb,
  input  logic                    i_wb_we,
  input  logic [1:0]              i_wb_addr,
  input  logic [31:0]             i_wb_data,
  output logic                    o_wb_ack,
  output logic                    o_wb_stall,
  output logic [31:0]             o_wb_data,
  output logic [SAMPLE_WIDTH-1:0] o_sample,
  output logic                    o_sample_stb,
  output logic                    o_underrun,
  output logic                    o_int
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]      FILL_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]      FILL_HALF = (FIFO_AW+1)'(DEPTH / 2);
  localparam logic [FIFO_AW:0]      FILL_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0]    PTR_ONE   = FIFO_AW'(1);
  localparam logic [RATE_WIDTH-1:0] RATE_ONE  = RATE_WIDTH'(1);

  logic [SAMPLE_WIDTH-1:0] mem [0:DEPTH-1];
  logic [SAMPLE_WIDTH-1:0] rd_dat_q;

  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]      fill_q, fill_d;
  logic [RATE_WIDTH-1:0] rate_q, rate_d, cnt_q, cnt_d;
  logic                  enable_q, enable_d, ovf_q, ovf_d;
  logic [31:0]           ucnt_q, ucnt_d;
  logic                  ack_q, ack_d, stb_q, stb_d, und_q, und_d;
  logic                  have_q, have_d;
  logic [31:0]           rdata_q, rdata_d, status;

  logic wb_req, wb_wr, push_req, rate_wr, ctrl_wr, ucnt_wr, flush;
  logic fifo_empty, fifo_full, tick, pop, underrun, push;
  logic unused_wb;

  assign wb_req     = i_wb_cyc & i_wb_stb;
  assign wb_wr      = wb_req & i_wb_we;
  assign push_req   = wb_wr & (i_wb_addr == 2'd0);
  assign rate_wr    = wb_wr & (i_wb_addr == 2'd1);
  assign ctrl_wr    = wb_wr & (i_wb_addr == 2'd2);
  assign ucnt_wr    = wb_wr & (i_wb_addr == 2'd3);
  assign flush      = ctrl_wr & i_wb_data[1];
  assign fifo_empty = (fill_q == '0);
  assign fifo_full  = (fill_q == FILL_FULL);
  // A flush cancels the whole tick so the FIFO and divider restart cleanly together.
  assign tick       = enable_q & (cnt_q == '0) & ~flush;
  assign pop        = tick & ~fifo_empty;
  assign underrun   = tick & fifo_empty;
  assign push       = push_req & ~flush & (~fifo_full | pop);
  assign unused_wb  = ^i_wb_data;

  always_comb begin
    status                  = '0;
    status[0]               = enable_q;
    status[1]               = fifo_empty;
    status[2]               = fifo_full;
    status[3]               = ovf_q;
    status[16 +: FIFO_AW+1] = fill_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    rate_d   = rate_q;
    cnt_d    = cnt_q;
    enable_d = enable_q;
    ovf_d    = ovf_q;
    ucnt_d   = ucnt_q;
    ack_d    = wb_req;
    rdata_d  = '0;
    stb_d    = pop;
    und_d    = underrun;
    have_d   = have_q | pop;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end

    if (rate_wr) rate_d = i_wb_data[RATE_WIDTH-1:0];
    if (!enable_q || flush || rate_wr || cnt_q == '0) cnt_d = rate_d;
    else                                                cnt_d = cnt_q - RATE_ONE;

    if (ctrl_wr) enable_d = i_wb_data[0];
    if (ctrl_wr && i_wb_data[2])                 ovf_d = 1'b0;
    else if (push_req && !flush && fifo_full && !pop) ovf_d = 1'b1;

    if (ucnt_wr)                      ucnt_d = '0;
    else if (underrun && ucnt_q != '1) ucnt_d = ucnt_q + 32'd1;

    if (wb_req) begin
      case (i_wb_addr)
        2'd1:    rdata_d[RATE_WIDTH-1:0] = rate_q;
        2'd2:    rdata_d = status;
        2'd3:    rdata_d = ucnt_q;
        default: rdata_d = '0;
      endcase
    end
  end

  // Storage has no reset and a read-first registered port so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= i_wb_data[SAMPLE_WIDTH-1:0];
    if (pop)  rd_dat_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      rate_q   <= '0;
      cnt_q    <= '0;
      enable_q <= 1'b0;
      ovf_q    <= 1'b0;
      ucnt_q   <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      stb_q    <= 1'b0;
      und_q    <= 1'b0;
      have_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      rate_q   <= rate_d;
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
      ovf_q    <= ovf_d;
      ucnt_q   <= ucnt_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      stb_q    <= stb_d;
      und_q    <= und_d;
      have_q   <= have_d;
    end
  end

  assign o_wb_ack     = ack_q;
  assign o_wb_stall   = 1'b0;
  assign o_wb_data    = rdata_q;
  // Until the first pop the RAM output register is meaningless, so present zero.
  assign o_sample     = have_q ? rd_dat_q : '0;
  assign o_sample_stb = stb_q;
  assign o_underrun   = und_q;
  assign o_int        = enable_q & (fill_q < FILL_HALF);
endmodule

// File: tb/tb_sample_stream_fifo.sv
// Cycle-level bench: a queue-and-timeline model predicts every bus and stream output.
module tb_sample_stream_fifo;
  localparam int DEPTH = 256;

  logic        i_clk, i_resetb;
  logic        i_wb_cyc, i_wb_stb, i_wb_we;
  logic [1:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_ack, o_wb_stall;
  logic [31:0] o_wb_data;
  logic [15:0] o_sample;
  logic        o_sample_stb, o_underrun, o_int;

  sample_stream_fifo dut (
    .i_clk(i_clk), .i_resetb(i_resetb),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
    .o_sample(o_sample), .o_sample_stb(o_sample_stb),
    .o_underrun(o_underrun), .o_int(o_int)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_tests, n_fail;
  int unsigned cnum;
  logic [15:0] q[$];
  logic        m_en, m_ovf;
  logic [15:0] m_rate, m_sample;
  logic [31:0] m_ucnt;
  int unsigned m_next;
  int          op;
  logic [31:0] rd_v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cnum);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_en = 1'b0; m_ovf = 1'b0; m_rate = '0; m_sample = '0; m_ucnt = '0; m_next = 0;
  endtask

  function automatic logic [31:0] read_model(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd1: v = {16'd0, m_rate};
      2'd2: begin
        v[0]     = m_en;
        v[1]     = (q.size() == 0);
        v[2]     = (q.size() == DEPTH);
        v[3]     = m_ovf;
        v[24:16] = 9'(q.size());
      end
      2'd3: v = m_ucnt;
      default: v = '0;
    endcase
    return v;
  endfunction

  // One clock: drive the bus, advance the model, then compare after the edge.
  task automatic cyc1(input logic cy, input logic st, input logic we,
                      input logic [1:0] a, input logic [31:0] d);
    logic        req, flush, ratewr, tick, popped, und;
    logic [31:0] rdv;
    int unsigned new_rate;
    i_wb_cyc = cy; i_wb_stb = st; i_wb_we = we; i_wb_addr = a; i_wb_data = d;
    req    = cy && st;
    flush  = req && we && a == 2'd2 && d[1];
    ratewr = req && we && a == 2'd1;
    tick   = m_en && (cnum == m_next) && !flush;
    rdv    = read_model(a);
    popped = 1'b0; und = 1'b0;
    if (tick) begin
      if (q.size() > 0) begin
        m_sample = q.pop_front();
        popped = 1'b1;
      end else begin
        und = 1'b1;
        if (m_ucnt != 32'hFFFF_FFFF) m_ucnt = m_ucnt + 32'd1;
      end
    end
    new_rate = ratewr ? 32'(d[15:0]) : 32'(m_rate);
    if (!m_en || flush || ratewr || tick) m_next = cnum + 1 + new_rate;
    if (req && we) begin
      case (a)
        2'd0: if (q.size() < DEPTH) q.push_back(d[15:0]); else m_ovf = 1'b1;
        2'd1: m_rate = d[15:0];
        2'd2: begin
          m_en = d[0];
          if (d[1]) q.delete();
          if (d[2]) m_ovf = 1'b0;
        end
        default: m_ucnt = '0;
      endcase
    end
    @(posedge i_clk);
    #1;
    cnum++;
    chk("ack", 32'(o_wb_ack), 32'(req));
    if (req && !we) chk($sformatf("rdata[%0d]", a), o_wb_data, rdv);
    chk("sample_stb", 32'(o_sample_stb), 32'(popped));
    chk("underrun", 32'(o_underrun), 32'(und));
    chk("sample", 32'(o_sample), 32'(m_sample));
    chk("int", 32'(o_int), 32'(m_en && q.size() < DEPTH / 2));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc1(1'b1, 1'b1, 1'b1, a, d);
  endtask
  task automatic rd(input logic [1:0] a);
    cyc1(1'b1, 1'b1, 1'b0, a, 32'd0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc1(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_ack"},  32'(o_wb_ack), 32'd0);
    chk({pfx, "_data"}, o_wb_data, 32'd0);
    chk({pfx, "_sample"}, 32'(o_sample), 32'd0);
    chk({pfx, "_stb"},  32'(o_sample_stb), 32'd0);
    chk({pfx, "_und"},  32'(o_underrun), 32'd0);
    chk({pfx, "_int"},  32'(o_int), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; cnum = 0;
    i_resetb = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_addr = '0; i_wb_data = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk_zero_outputs("reset");
    chk("stall", 32'(o_wb_stall), 32'd0);
    i_resetb = 1'b1;

    // Two samples at period 4, then periodic underruns with a running count.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h0000_1111);
    wr(2'd0, 32'hABCD_2222);
    wr(2'd2, 32'd1);
    for (int i = 0; i < 6; i++) begin
      idle(3);
      rd(2'd3);
    end
    rd(2'd1);

    // Strobe without cycle must be invisible.
    cyc1(1'b0, 1'b1, 1'b1, 2'd1, 32'd9);
    rd(2'd1);

    // Overflow: 257 pushes while disabled.
    wr(2'd2, 32'd2);
    for (int i = 0; i < DEPTH + 1; i++) wr(2'd0, $urandom);
    rd(2'd2);

    // Full FIFO at RATE=0: push every cycle keeps it full without overflow.
    wr(2'd2, 32'd4);
    wr(2'd1, 32'd0);
    rd(2'd2);
    wr(2'd2, 32'd1);
    for (int i = 0; i < 24; i++) wr(2'd0, $urandom);
    rd(2'd2);
    wr(2'd2, 32'd0);
    rd(2'd2);

    // Flush with 10 queued samples.
    wr(2'd2, 32'd2);
    for (int i = 0; i < 10; i++) wr(2'd0, $urandom);
    wr(2'd2, 32'd2);
    rd(2'd2);
    idle(3);

    // Interrupt threshold at half depth, then clear the underrun count.
    wr(2'd1, 32'd2000);
    wr(2'd2, 32'd1);
    for (int i = 0; i < DEPTH / 2 - 1; i++) wr(2'd0, $urandom);
    rd(2'd2);
    wr(2'd0, $urandom);
    rd(2'd2);
    rd(2'd3);
    wr(2'd3, 32'd0);
    rd(2'd3);
    wr(2'd2, 32'd2);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: wr(2'd0, $urandom);
        4: rd(2'($urandom_range(0, 3)));
        5: wr(2'd1, 32'($urandom_range(0, 6)));
        6: begin
          rd_v = '0;
          rd_v[0] = ($urandom_range(0, 3) != 0);
          rd_v[1] = ($urandom_range(0, 7) == 0);
          rd_v[2] = ($urandom_range(0, 3) == 0);
          wr(2'd2, rd_v);
        end
        7: wr(2'd3, $urandom);
        8: cyc1(1'b0, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
        default: idle(1);
      endcase
    end

    // Reset while streaming with a strobe awaiting its ack.
    wr(2'd1, 32'd2);
    wr(2'd2, 32'd1);
    for (int i = 0; i < 5; i++) wr(2'd0, $urandom);
    idle(7);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 2'd2;
    #3;
    i_resetb = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    @(posedge i_clk);
    #1;
    chk("midreset_noack", 32'(o_wb_ack), 32'd0);
    i_resetb = 1'b1;
    model_reset();
    idle(3);
    rd(2'd2);
    rd(2'd1);
    rd(2'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
